// File: rtl/wb_host_master_pkg.sv
// rtl/wb_host_master_pkg.sv - shared types for the Wishbone host master
package wb_host_master_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ERR     = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_RETRY   = 2'b11
  } wb_status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUS  = 2'b01,
    S_GAP  = 2'b10,
    S_RESP = 2'b11
  } wb_state_e;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
  } wb_req_t;

  typedef struct packed {
    logic [31:0] dat;
    wb_status_e  status;
  } wb_rsp_t;

endpackage

// File: rtl/wb_host_master_timer.sv
// rtl/wb_host_master_timer.sv - per-attempt bus timeout counter (load / increment / expire)
module wb_host_master_timer #(
  parameter int LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_inc,
  output logic o_expire
);
  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] r_count;

  // Count idle bus cycles of the current attempt; load restarts from zero
  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry fires on the LIMIT-th consecutive idle cycle of an attempt
  assign o_expire = i_inc && (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/wb_host_master.sv
// rtl/wb_host_master.sv - Wishbone classic single-transfer initiator; optional timeout under WB_HOST_MASTER_TIMEOUT_EN
module wb_host_master
  import wb_host_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  input  logic        req_we,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic [1:0]  rsp_status,
  output logic        busy,
  output logic [31:0] wb_m2s_adr,
  output logic [31:0] wb_m2s_dat,
  output logic [3:0]  wb_m2s_sel,
  output logic        wb_m2s_we,
  output logic        wb_m2s_cyc,
  output logic        wb_m2s_stb,
  input  logic [31:0] wb_s2m_dat,
  input  logic        wb_s2m_ack,
  input  logic        wb_s2m_err,
  input  logic        wb_s2m_rty
);
  localparam logic [7:0] MAX_RETRY_W = 8'(MAX_RETRY);

  wb_state_e  r_state;
  wb_state_e  w_next;
  wb_req_t    r_req;
  wb_rsp_t    r_rsp;
  logic       r_cyc;
  logic [7:0] r_retry;

  logic w_accept;
  logic w_in_bus;
  logic w_ack;
  logic w_err;
  logic w_rty;
  logic w_term;
  logic w_retry_left;
  logic w_expire;

  assign w_accept     = req_valid & req_ready;
  assign w_in_bus     = (r_state == S_BUS) & r_cyc;
  assign w_ack        = w_in_bus & wb_s2m_ack;
  assign w_err        = w_in_bus & wb_s2m_err;
  assign w_rty        = w_in_bus & wb_s2m_rty;
  assign w_term       = w_ack | w_err | w_rty;
  assign w_retry_left = (r_retry < MAX_RETRY_W);

`ifdef WB_HOST_MASTER_TIMEOUT_EN
  logic w_timer_load;
  logic w_timer_inc;

  assign w_timer_load = w_accept | (r_state == S_GAP);
  assign w_timer_inc  = (r_state == S_BUS) & ~w_term;

  wb_host_master_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (wb_clk),
    .i_rst    (wb_rst),
    .i_load   (w_timer_load),
    .i_inc    (w_timer_inc),
    .o_expire (w_expire)
  );
`else
  // Without the timer a stuck slave simply holds the bus
  assign w_expire = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // State register
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; ack beats err beats rty, and any termination beats expiry
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_BUS;
      S_BUS: begin
        if (w_ack || w_err)  w_next = S_RESP;
        else if (w_rty)      w_next = w_retry_left ? S_GAP : S_RESP;
        else if (w_expire)   w_next = S_RESP;
      end
      S_GAP:  w_next = S_BUS;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; no acceptance while reset is held
  always_comb begin
    req_ready = (r_state == S_IDLE) & ~wb_rst;
    rsp_valid = (r_state == S_RESP);
    busy      = (r_state != S_IDLE);
  end

  // Bus-side registers: request latch, cyc/stb, retry count and captured response
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_req   <= '0;
      r_rsp   <= '0;
      r_cyc   <= 1'b0;
      r_retry <= '0;
    end else begin
      r_cyc <= (w_next == S_BUS);
      if (w_accept) begin
        r_req   <= '{adr: req_adr, dat: req_dat, sel: req_sel, we: req_we};
        r_retry <= '0;
        r_rsp   <= '0;
      end
      if (r_state == S_BUS) begin
        if (w_ack) begin
          r_rsp.dat    <= r_req.we ? 32'd0 : wb_s2m_dat;
          r_rsp.status <= ST_OK;
        end else if (w_err) begin
          r_rsp.dat    <= '0;
          r_rsp.status <= ST_ERR;
        end else if (w_rty) begin
          if (w_retry_left) begin
            r_retry <= r_retry + 8'd1;
          end else begin
            r_rsp.dat    <= '0;
            r_rsp.status <= ST_RETRY;
          end
        end else if (w_expire) begin
          r_rsp.dat    <= '0;
          r_rsp.status <= ST_TIMEOUT;
        end
      end
    end
  end

  assign wb_m2s_adr = r_req.adr;
  assign wb_m2s_dat = r_req.dat;
  assign wb_m2s_sel = r_req.sel;
  assign wb_m2s_we  = r_req.we;
  assign wb_m2s_cyc = r_cyc;
  assign wb_m2s_stb = r_cyc;
  assign rsp_dat    = r_rsp.dat;
  assign rsp_status = r_rsp.status;

endmodule

// File: tb/tb_wb_host_master.sv
// tb/tb_wb_host_master.sv - scoreboard bench for wb_host_master with scripted slave and reference model
module tb_wb_host_master;

  localparam int TO = 16;
  localparam int MR = 3;
`ifdef WB_HOST_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [1:0] E_OK = 2'd0, E_ERR = 2'd1, E_TO = 2'd2, E_RTY = 2'd3;
  localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_ALL = 3, K_ER = 4;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_adr = '0;
  logic [31:0] req_dat = '0;
  logic [3:0]  req_sel = '0;
  logic        req_we = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [31:0] wb_m2s_adr, wb_m2s_dat;
  logic [3:0]  wb_m2s_sel;
  logic        wb_m2s_we, wb_m2s_cyc, wb_m2s_stb;
  logic [31:0] wb_s2m_dat = '0;
  logic        wb_s2m_ack = 1'b0;
  logic        wb_s2m_err = 1'b0;
  logic        wb_s2m_rty = 1'b0;

  wb_host_master #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_adr(req_adr), .req_dat(req_dat),
    .req_sel(req_sel), .req_we(req_we),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .busy(busy),
    .wb_m2s_adr(wb_m2s_adr), .wb_m2s_dat(wb_m2s_dat), .wb_m2s_sel(wb_m2s_sel),
    .wb_m2s_we(wb_m2s_we), .wb_m2s_cyc(wb_m2s_cyc), .wb_m2s_stb(wb_m2s_stb),
    .wb_s2m_dat(wb_s2m_dat), .wb_s2m_ack(wb_s2m_ack), .wb_s2m_err(wb_s2m_err),
    .wb_s2m_rty(wb_s2m_rty)
  );

  int n_tests = 0;
  int n_fail = 0;
  int cycnum = 0;
  int hs_cyc = 0;
  int done_cnt = 0;
  int stall_n = 0;
  bit rnd_ready = 1'b0;
  bit no_chk = 1'b0;

  int          s_kind[8];
  int          s_wait[8];
  logic [31:0] s_rdata[8];
  int          att = 0;
  logic [31:0] cur_adr, cur_dat;
  logic [3:0]  cur_sel;
  logic        cur_we;

  logic [31:0] q_dat[$];
  logic [1:0]  q_st[$];
  int          q_lat[$];

  initial forever #5 wb_clk = ~wb_clk;
  initial forever begin @(posedge wb_clk); cycnum++; end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got stuck, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cycnum);
    end
  endtask

  // Expected outcome from the bus rules: walk attempts, each costs wait+1 bus cycles plus one gap
  function automatic void model(input logic we, output logic [31:0] edat,
                                output logic [1:0] est, output int elat);
    edat = '0;
    est  = E_OK;
    elat = 1;
    for (int i = 0; i <= MR; i++) begin
      if (TO_EN && s_wait[i] >= TO) begin
        elat += TO;
        est = E_TO;
        return;
      end
      elat += s_wait[i] + 1;
      if (s_kind[i] == K_ACK || s_kind[i] == K_ALL) begin
        est  = E_OK;
        edat = we ? 32'd0 : s_rdata[i];
        return;
      end
      if (s_kind[i] == K_ERR || s_kind[i] == K_ER) begin
        est = E_ERR;
        return;
      end
      if (i == MR) begin
        est = E_RTY;
        return;
      end
      elat += 1;
    end
  endfunction

  function automatic int explen(input int a);
    return (TO_EN && s_wait[a] >= TO) ? TO : s_wait[a] + 1;
  endfunction

  task automatic set_script(input int k, input int w, input logic [31:0] d);
    for (int i = 0; i < 8; i++) begin
      s_kind[i] = k;
      s_wait[i] = w;
      s_rdata[i] = d;
    end
  endtask

  // Scripted slave: terminates attempt `att` after s_wait cycles, drives noise while cyc is low
  initial begin
    int  cc;
    int  idle;
    int  a;
    bit  in_cyc;
    bit  hit;
    cc = 0; idle = 0; in_cyc = 0;
    forever begin
      @(posedge wb_clk); #1;
      a = (att < 8) ? att : 7;
      if (wb_m2s_cyc) begin
        if (!in_cyc) begin
          in_cyc = 1;
          cc = 0;
          if (att > 0 && !no_chk) check("gap_cycles", idle, 1);
          check("bus_adr", wb_m2s_adr, cur_adr);
          check("bus_we_sel_dat_stb", {wb_m2s_stb, wb_m2s_we, wb_m2s_sel, wb_m2s_dat},
                {1'b1, cur_we, cur_sel, cur_dat});
        end else begin
          cc++;
        end
        hit = (cc == s_wait[a]);
        wb_s2m_ack = hit && (s_kind[a] == K_ACK || s_kind[a] == K_ALL);
        wb_s2m_err = hit && (s_kind[a] == K_ERR || s_kind[a] == K_ALL || s_kind[a] == K_ER);
        wb_s2m_rty = hit && (s_kind[a] == K_RTY || s_kind[a] == K_ALL || s_kind[a] == K_ER);
        wb_s2m_dat = hit ? s_rdata[a] : $urandom;
      end else begin
        wb_s2m_ack = ($urandom_range(0, 3) == 0);
        wb_s2m_err = ($urandom_range(0, 3) == 0);
        wb_s2m_rty = ($urandom_range(0, 3) == 0);
        wb_s2m_dat = $urandom;
        if (in_cyc) begin
          in_cyc = 0;
          if (!no_chk) check("cyc_len", cc + 1, explen(a));
          att++;
          idle = 1;
        end else begin
          idle++;
        end
      end
    end
  end

  // Response consumer: optional forced stall, then random or always-ready
  initial begin
    forever begin
      @(posedge wb_clk); #1;
      if (stall_n > 0) begin
        rsp_ready = 1'b0;
        if (rsp_valid) stall_n--;
      end else begin
        rsp_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: latency on first valid, stability while stalled, compare on handshake
  initial begin
    bit          pend;
    bit          seen;
    logic [31:0] h_dat;
    logic [1:0]  h_st;
    logic [31:0] e_dat;
    logic [1:0]  e_st;
    pend = 0; seen = 0; h_dat = '0; h_st = '0;
    forever begin
      @(negedge wb_clk);
      if (wb_rst) begin
        pend = 0;
        seen = 0;
      end else if (rsp_valid) begin
        if (q_dat.size() == 0) begin
          if (rsp_ready) check("unexpected_rsp", 1, 0);
        end else begin
          if (!seen) begin
            seen = 1;
            check("latency", cycnum - hs_cyc, q_lat[0]);
            check("busy_in_resp", busy, 1);
          end
          if (pend) begin
            check("rsp_dat_stable", rsp_dat, h_dat);
            check("rsp_status_stable", rsp_status, h_st);
            check("req_ready_in_resp", req_ready, 0);
          end
          if (rsp_ready) begin
            e_dat = q_dat.pop_front();
            e_st  = q_st.pop_front();
            void'(q_lat.pop_front());
            check("rsp_dat", rsp_dat, e_dat);
            check("rsp_status", rsp_status, e_st);
            pend = 0;
            seen = 0;
            done_cnt++;
          end else begin
            pend  = 1;
            h_dat = rsp_dat;
            h_st  = rsp_status;
          end
        end
      end
    end
  end

  // Issue one command; rst_after > 0 pulses reset that many cycles into the bus phase
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int rst_after);
    logic [31:0] edat;
    logic [1:0]  est;
    int          elat;
    int          t;
    bit          ok;
    int          target;
    target = done_cnt + 1;
    if (rst_after == 0) begin
      model(we, edat, est, elat);
      q_dat.push_back(edat);
      q_st.push_back(est);
      q_lat.push_back(elat);
    end
    no_chk  = (rst_after != 0);
    cur_we  = we;
    cur_adr = adr;
    cur_dat = dat;
    cur_sel = sel;
    att     = 0;
    @(posedge wb_clk); #1;
    req_valid = 1'b1;
    req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    ok = 0; t = 0;
    while (!ok && t < 50) begin
      @(negedge wb_clk);
      if (req_ready) begin
        ok = 1;
        hs_cyc = cycnum;
      end
      t++;
    end
    check("req_accepted", ok, 1);
    @(posedge wb_clk); #1;
    req_valid = 1'b0;
    req_adr = $urandom; req_dat = $urandom; req_sel = 4'($urandom); req_we = 1'($urandom);
    if (rst_after != 0) begin
      repeat (rst_after - 1) @(posedge wb_clk);
      @(negedge wb_clk);
      check("cyc_before_reset", wb_m2s_cyc, 1);
      @(posedge wb_clk); #1;
      wb_rst = 1'b1;
      @(posedge wb_clk); #1;
      wb_rst = 1'b0;
      @(negedge wb_clk);
      check("rst_cyc_stb", {wb_m2s_cyc, wb_m2s_stb}, 2'b00);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 1);
      repeat (30) @(posedge wb_clk);
      check("no_rsp_after_reset", done_cnt, target - 1);
    end else begin
      t = 0;
      while (done_cnt < target && t < 500) begin
        @(posedge wb_clk);
        t++;
      end
      check("rsp_arrived", done_cnt >= target, 1);
    end
  endtask

  initial begin
    int r;
    repeat (3) @(posedge wb_clk);
    @(negedge wb_clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_req_ready", req_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_cyc_stb", {wb_m2s_cyc, wb_m2s_stb}, 2'b00);
    check("reset_rsp", {rsp_dat, rsp_status}, 34'd0);
    check("reset_bus_regs", {wb_m2s_adr, wb_m2s_sel, wb_m2s_we}, 37'd0);
    @(posedge wb_clk); #1;
    wb_rst = 1'b0;
    @(negedge wb_clk);
    check("req_ready_after_reset", req_ready, 1);

    // Read acked on the second bus cycle
    set_script(K_ACK, 1, 32'h0000_00A5);
    issue(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    // Write acked on the first bus cycle
    set_script(K_ACK, 0, 32'hFFFF_FFFF);
    issue(1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 0);
    // Retry on every attempt
    set_script(K_RTY, 0, 32'h1111_1111);
    issue(1'b0, 32'h0000_0030, 32'h0, 4'h3, 0);
    // Late ack: timeout when enabled, otherwise completes
    set_script(K_ACK, 40, 32'h0BAD_F00D);
    issue(1'b0, 32'h0000_0040, 32'h0, 4'hF, 0);
    // ack+err+rty together, response stalled five cycles
    set_script(K_ALL, 0, 32'h5A5A_5A5A);
    stall_n = 5;
    issue(1'b0, 32'h0000_0044, 32'h0, 4'hF, 0);
    // Error after one retry
    set_script(K_ERR, 2, 32'h0);
    s_kind[0] = K_RTY;
    issue(1'b1, 32'h0000_0048, 32'hCAFE_0001, 4'h1, 0);
    // Reset in the middle of a bus cycle
    set_script(K_ACK, 1000, 32'h0);
    issue(1'b0, 32'h0000_0050, 32'h0, 4'hF, 3);

    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++) begin
        r = $urandom_range(0, 7);
        s_kind[i]  = (r <= 2) ? K_ACK : (r == 3) ? K_ERR : (r <= 5) ? K_RTY : (r == 6) ? K_ALL : K_ER;
        s_wait[i]  = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 3);
        s_rdata[i] = $urandom;
      end
      issue(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), 0);
    end

    repeat (5) @(posedge wb_clk);
    check("queue_drained", q_dat.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
# wb_host_master

Wishbone classic single-transfer initiator that drives the `wb_m2s_*` / `wb_s2m_*` port set of the peripheral SoC top (SPI, I2C, UART slaves behind the interconnect). It accepts one read or write command at a time on a valid/ready request channel and runs the bus cycle. It retries on `rty`, optionally aborts on a hung slave, and returns read data plus a status on a valid/ready response channel. It is the bus-side core for the host bridge and for bench-side firmware emulation.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum cycles `cyc` may stay high per attempt without a termination.
- `MAX_RETRY`, 3: maximum number of reissues after `rty`; 0 disables retry.
- `wb_clk` input 1: single clock, all logic on its rising edge.
- `wb_rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: command present.
- `req_ready` output 1: command accepted when high together with `req_valid`.
- `req_adr` input 32: byte address.
- `req_dat` input 32: write data.
- `req_sel` input 4: byte select.
- `req_we` input 1: 1 = write, 0 = read.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: response consumed.
- `rsp_dat` output 32: read data (0 for writes and failures).
- `rsp_status` output 2: completion status, see package.
- `busy` output 1: high from accept until the response is consumed.
- `wb_m2s_adr` output 32, `wb_m2s_dat` output 32, `wb_m2s_sel` output 4, `wb_m2s_we` output 1, `wb_m2s_cyc` output 1, `wb_m2s_stb` output 1: bus outputs, all registered.
- `wb_s2m_dat` input 32, `wb_s2m_ack` input 1, `wb_s2m_err` input 1, `wb_s2m_rty` input 1: bus inputs.

## Operation
- FSM states: IDLE, BUS, GAP, RESP.
- IDLE: `req_ready`=1. On the handshake, latch adr/dat/sel/we into the `wb_m2s_*` registers, clear the retry and timeout counters, and go to BUS with `cyc`=`stb`=1.
- BUS: terminations are sampled only while `cyc`&`stb`. Priority is ack > err > rty.
  - ack: capture `wb_s2m_dat` (reads only), status OK, go to RESP.
  - err: status ERR, go to RESP.
  - rty with retry count < `MAX_RETRY`: increment the count and go to GAP.
  - rty with retry count = `MAX_RETRY`: status RETRY, go to RESP.
- GAP: `cyc`=`stb`=0 for exactly one cycle, then back to BUS with the same address and data. The timeout counter restarts.
- RESP: `cyc`=`stb`=0 and `rsp_valid`=1, with `rsp_dat` and `rsp_status` held stable until `rsp_ready`. Then go to IDLE.
- `req_ready`=0 outside IDLE. No command pipelining: at most one transaction is outstanding.
- Termination inputs are ignored outside BUS.
- `wb_m2s_adr/dat/sel/we` keep their last values after a cycle ends. Slaves must not rely on them while `cyc`=0.

## Timing
- Reset value of every output is 0 (`req_ready` is 1 from the first cycle after reset).
- Reset is accepted in any state. The next edge forces IDLE, drops `cyc`/`stb`, and discards any pending response.
- Handshake at edge N puts `cyc`/`stb` high from N+1.
- A termination sampled at edge M drops `cyc`/`stb` and raises `rsp_valid` in the same cycle after M.
- Minimum latency from request handshake to `rsp_valid` is 2 cycles (ack in the first bus cycle).
- When ack, err and rty are asserted simultaneously, ack wins.
- `rsp_valid` and `rsp_ready` high at edge K: `req_ready` goes high after K. The next request can be accepted at K+1.

## Configuration
- `WB_HOST_MASTER_TIMEOUT_EN` defined:
  - A per-attempt counter increments every BUS cycle with no termination.
  - When it reaches `TIMEOUT_CYCLES`, `cyc`/`stb` drop and the block enters RESP with status TIMEOUT and `rsp_dat`=0.
  - A termination arriving on the same edge as expiry wins over the timeout.
- Not defined: no counter is built, BUS waits indefinitely, and TIMEOUT is never reported.

## Structure
- Package `wb_host_master_pkg` holds:
  - the status enum: OK=2'b00, ERR=2'b01, TIMEOUT=2'b10, RETRY=2'b11;
  - the FSM state enum;
  - the request and response struct typedefs.
- One sub-module, `wb_host_master_timer`, holds the load/increment/expire timeout counter. It is instantiated only under the macro.

## Test plan
- Read 0x0000_0010, slave acks on 2nd bus cycle with 0x0000_00A5 -> `rsp_dat`=0x0000_00A5, status OK, `cyc` high exactly 2 cycles.
- Write 0x1234_5678 with sel 4'hF, slave acks on 1st bus cycle -> `rsp_valid` 2 cycles after handshake, status OK, `rsp_dat`=0.
- Slave asserts rty on every attempt, `MAX_RETRY`=3 -> 4 `cyc` pulses each separated by one idle cycle, status RETRY.
- Slave never responds, macro on, `TIMEOUT_CYCLES`=16 -> `cyc` high 16 cycles, then status TIMEOUT. Macro off: `cyc` stays high and a late ack completes with OK.
- ack+err asserted together -> status OK. `rsp_ready` held low 5 cycles -> response stable and `req_ready`=0 throughout.
- `wb_rst` asserted mid-BUS -> next cycle `cyc`=`stb`=0, `rsp_valid`=0, `req_ready`=1, and no response is ever emitted.
